mul_uint4_arbiter: RTL and testbench
====================================

MUL_UINT4_ARBITER -- requirements
Module: mul_uint4_arbiter

Interface
REQ-001 The parameter list SHALL be: NUM_REQ, default 2, number of requesters sharing one multiplier, legal range 2..4.
REQ-002 clk  input  1  single clock; all state SHALL change on its rising edge.
REQ-003 rst_n  input  1  reset, asynchronous assertion, active-low.
REQ-004 req_valid  input  NUM_REQ  per-requester operand-valid flag.
REQ-005 req_ready  output  NUM_REQ  per-requester accept flag; at most one bit high per cycle.
REQ-006 req_a  input  4*NUM_REQ  packed multiplicands; requester i uses bits [4i+3:4i].
REQ-007 req_b  input  4*NUM_REQ  packed multipliers; requester i uses bits [4i+3:4i].
REQ-008 res_valid  output  1  result register holds a valid product.
REQ-009 res_ready  input  1  consumer accepts the result.
REQ-010 res_p  output  4  lower 4 bits of A*B, unsigned (modulo 16).
REQ-011 res_id  output  2  index of the requester that owns res_p.
REQ-012 ops_done  output  8  count of results consumed, modulo 256.

Function
REQ-013 A transfer on requester i SHALL occur when req_valid[i] and req_ready[i] are both 1 at a rising edge.
REQ-014 The arbiter SHALL drive req_ready[i]=1 only when i is the grant winner and the result slot is free, or is draining that same cycle (res_valid=1 and res_ready=1).
REQ-015 The grant winner SHALL be chosen round-robin: the search starts at rr_ptr and wraps from NUM_REQ-1 to 0.
REQ-016 rr_ptr SHALL advance to (granted index + 1) mod NUM_REQ after each transfer, and SHALL be unchanged otherwise.
REQ-017 The product SHALL be computed combinationally from the granted operands by one mul_uint4 instance and registered on transfer.
REQ-018 Latency from transfer to res_valid=1 SHALL be exactly 1 cycle, which allows one accepted operation per cycle under full throughput.
REQ-019 The control state machine SHALL have two states.
- EMPTY: res_valid=0. Goes to FULL on any transfer.
- FULL: res_valid=1. Goes to EMPTY on drain without a new transfer. Stays in FULL on drain with a same-cycle transfer, with res_p and res_id updated. Stays in FULL on no drain.
REQ-020 While res_valid=1 and res_ready=0, res_p and res_id SHALL hold stable and all req_ready bits SHALL be 0.
REQ-021 req_ready SHALL NOT depend combinationally on req_valid of non-winning requesters; it MAY depend on res_ready.
REQ-022 ops_done SHALL increment on each res_valid and res_ready handshake and wrap from 255 to 0.
REQ-023 Requesters with req_valid=0 SHALL never be granted; when no requester is valid, no transfer occurs and rr_ptr holds.
REQ-024 The product width rule SHALL be res_p = (A*B) mod 16 (for example, 15*15 gives 1).

Reset
REQ-025 While rst_n=0, the state SHALL be EMPTY, res_valid=0, req_ready=0, res_p=0, res_id=0, rr_ptr=0, and ops_done=0.
REQ-026 Reset asserted mid-operation SHALL discard any held result without a handshake; ops_done SHALL clear.
REQ-027 On the first rising edge after rst_n deasserts, the block SHALL be able to accept a transfer.

Structure
REQ-028 The ID width (2), operand width (4) and state encodings SHALL live in a shared header/package used by the block and its bench.
REQ-029 Exactly one mul_uint4 instance SHALL be used; the round-robin search SHALL be a separate sub-module, rr_arbiter, parameterised by NUM_REQ.

Verification
REQ-030 Single request: requester 0 sends A=7, B=3 -> next cycle res_valid=1, res_p=5, res_id=0.
REQ-031 Contention, NUM_REQ=2, both valid every cycle, res_ready=1 -> grants alternate 0,1,0,1; one result per cycle; ops_done=4 after 4 drains.
REQ-032 Backpressure: hold res_ready=0 for 3 cycles with a result of A=15, B=15 -> res_p=1 stable, req_ready=0 throughout; release -> drain and accept in the same cycle.
REQ-033 Wrap: 256 drained results -> ops_done returns to 0; with NUM_REQ=3 and requesters 1 and 2 only valid -> grants 1,2,1,2.
REQ-034 Reset mid-FULL: pulse rst_n=0 while res_valid=1 -> res_valid=0, ops_done=0, rr_ptr=0 immediately (asynchronously).
REQ-035 Exhaustive: all 256 A,B pairs on requester 1 -> res_p matches (A*B) mod 16 for every pair.

Source files
------------

// File: rtl/mul_uint4_arbiter_pkg.sv
// Shared widths and control-state encoding for the multiplier arbiter and its bench.
package mul_uint4_arbiter_pkg;

  localparam int unsigned ID_W = 2;
  localparam int unsigned OP_W = 4;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

endpackage

// File: rtl/mul_uint4_arbiter_mul.sv
// Unsigned 4x4 multiplier keeping only the low operand-width bits of the product.
module mul_uint4
  import mul_uint4_arbiter_pkg::*;
(
  input  logic [OP_W-1:0] a,
  input  logic [OP_W-1:0] b,
  output logic [OP_W-1:0] p
);

  // Product truncated to the operand width, i.e. (a*b) mod 16.
  assign p = a * b;

endmodule

// File: rtl/mul_uint4_arbiter_rr_arbiter.sv
// Round-robin winner search: first valid requester at or above ptr, else wrap to the lowest.
module rr_arbiter
  import mul_uint4_arbiter_pkg::*;
#(
  parameter int unsigned NUM_REQ = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    ptr,
  output logic               gnt_valid,
  output logic [ID_W-1:0]    gnt_idx
);

  logic [NUM_REQ-1:0] upper;

  // The wrapped search is split into two lowest-set-bit scans: requests at or above
  // ptr take priority, otherwise the lowest request overall wins.
  always_comb begin
    upper     = '0;
    gnt_valid = |req;
    gnt_idx   = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      upper[i] = req[i] && (ID_W'(i) >= ptr);
    end
    for (int unsigned i = NUM_REQ; i > 0; i--) begin
      if (req[i-1]) gnt_idx = ID_W'(i-1);
    end
    for (int unsigned i = NUM_REQ; i > 0; i--) begin
      if (upper[i-1]) gnt_idx = ID_W'(i-1);
    end
  end

endmodule

// File: rtl/mul_uint4_arbiter.sv
// NUM_REQ requesters share one 4-bit multiplier through a one-entry result register.
module mul_uint4_arbiter
  import mul_uint4_arbiter_pkg::*;
#(
  parameter int unsigned NUM_REQ = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_REQ-1:0]      req_valid,
  output logic [NUM_REQ-1:0]      req_ready,
  input  logic [OP_W*NUM_REQ-1:0] req_a,
  input  logic [OP_W*NUM_REQ-1:0] req_b,
  output logic                    res_valid,
  input  logic                    res_ready,
  output logic [OP_W-1:0]         res_p,
  output logic [ID_W-1:0]         res_id,
  output logic [7:0]              ops_done
);

  state_t          state, state_next;
  logic [ID_W-1:0] rr_ptr;
  logic [ID_W-1:0] gnt_idx;
  logic            gnt_valid;
  logic            slot_free;
  logic            transfer;
  logic            drain;
  logic [OP_W-1:0] op_a, op_b, product;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
    .req       (req_valid),
    .ptr       (rr_ptr),
    .gnt_valid (gnt_valid),
    .gnt_idx   (gnt_idx)
  );

  mul_uint4 u_mul (
    .a (op_a),
    .b (op_b),
    .p (product)
  );

  assign res_valid = (state == FULL);
  assign drain     = res_valid && res_ready;
  assign slot_free = !res_valid || res_ready;
  // rst_n gates the accept path so nothing looks ready while reset is held.
  assign transfer  = rst_n && slot_free && gnt_valid;

  // One-hot accept toward the current winner only.
  always_comb begin
    req_ready = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      req_ready[i] = transfer && (gnt_idx == ID_W'(i));
    end
  end

  // Route the winner's operands to the shared multiplier.
  always_comb begin
    op_a = '0;
    op_b = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (gnt_idx == ID_W'(i)) begin
        op_a = req_a[i*OP_W +: OP_W];
        op_b = req_b[i*OP_W +: OP_W];
      end
    end
  end

  // Control state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= EMPTY;
    else        state <= state_next;
  end

  // Result slot occupancy: fill on transfer, empty on a drain with no refill.
  always_comb begin
    state_next = state;
    unique case (state)
      EMPTY: if (transfer)           state_next = FULL;
      FULL:  if (drain && !transfer) state_next = EMPTY;
      default:                       state_next = EMPTY;
    endcase
  end

  // Result capture, round-robin pointer and drain counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_p    <= '0;
      res_id   <= '0;
      rr_ptr   <= '0;
      ops_done <= '0;
    end else begin
      if (transfer) begin
        res_p  <= product;
        res_id <= gnt_idx;
        rr_ptr <= (gnt_idx == ID_W'(NUM_REQ-1)) ? '0 : gnt_idx + 1'b1;
      end
      if (drain) ops_done <= ops_done + 8'd1;
    end
  end

endmodule

// File: tb/tb_mul_uint4_arbiter.sv
// Bench for mul_uint4_arbiter: directed table, corner sequences and a random run against a model.
module tb_mul_uint4_arbiter;
  import mul_uint4_arbiter_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n = 1'b0;

  logic [1:0] req_valid = '0, req_ready;
  logic [7:0] req_a = '0, req_b = '0;
  logic       res_valid, res_ready = 1'b0;
  logic [3:0] res_p;
  logic [1:0] res_id;
  logic [7:0] ops_done;

  logic [2:0]  valid3 = '0, ready3;
  logic [11:0] a3 = '0, b3 = '0;
  logic        rv3, rdy3 = 1'b0;
  logic [3:0]  p3;
  logic [1:0]  id3;
  logic [7:0]  ops3;

  mul_uint4_arbiter #(.NUM_REQ(2)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .res_valid(res_valid), .res_ready(res_ready),
    .res_p(res_p), .res_id(res_id), .ops_done(ops_done)
  );

  mul_uint4_arbiter #(.NUM_REQ(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .req_valid(valid3), .req_ready(ready3),
    .req_a(a3), .req_b(b3), .res_valid(rv3), .res_ready(rdy3),
    .res_p(p3), .res_id(id3), .ops_done(ops3)
  );

  int n_vec = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [1:0] valid;
    logic [3:0] a0, b0, a1, b1;
    logic       rdy;
    logic [1:0] e_ready;
    logic       e_rvalid;
    logic [3:0] e_p;
    logic [1:0] e_id;
    logic [7:0] e_ops;
  } vec_t;

  vec_t vecs[9];

  task automatic cyc2(input logic [1:0] v, input logic [3:0] a0, input logic [3:0] b0,
                      input logic [3:0] a1, input logic [3:0] b1, input logic rdy);
    @(negedge clk);
    req_valid = v;
    req_a     = {a1, a0};
    req_b     = {b1, b0};
    res_ready = rdy;
    #1;
  endtask

  // Reset with requests asserted; release 2 time units after a rising edge.
  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; req_valid = '1; res_ready = 1'b1; valid3 = '1; rdy3 = 1'b1;
    #1;
    check("rst_ready",  32'(req_ready), 32'd0);
    check("rst_valid",  32'(res_valid), 32'd0);
    check("rst_p",      32'(res_p),     32'd0);
    check("rst_id",     32'(res_id),    32'd0);
    check("rst_ops",    32'(ops_done),  32'd0);
    check("rst3_ready", 32'(ready3),    32'd0);
    check("rst3_valid", 32'(rv3),       32'd0);
    check("rst3_ops",   32'(ops3),      32'd0);
    @(posedge clk);
    #2;
    rst_n = 1'b1; req_valid = '0; valid3 = '0;
  endtask

  initial begin
    // Single request, backpressure on 15*15, drain with same-cycle accept, then empty.
    vecs[0] = '{2'b01, 4'd7, 4'd3, 4'd0,  4'd0,  1'b0, 2'b01, 1'b0, 4'd0, 2'd0, 8'd0};
    vecs[1] = '{2'b00, 4'd0, 4'd0, 4'd0,  4'd0,  1'b0, 2'b00, 1'b1, 4'd5, 2'd0, 8'd0};
    vecs[2] = '{2'b10, 4'd0, 4'd0, 4'd15, 4'd15, 1'b1, 2'b10, 1'b1, 4'd5, 2'd0, 8'd0};
    vecs[3] = '{2'b01, 4'd2, 4'd2, 4'd0,  4'd0,  1'b0, 2'b00, 1'b1, 4'd1, 2'd1, 8'd1};
    vecs[4] = '{2'b01, 4'd2, 4'd2, 4'd0,  4'd0,  1'b0, 2'b00, 1'b1, 4'd1, 2'd1, 8'd1};
    vecs[5] = '{2'b01, 4'd2, 4'd2, 4'd0,  4'd0,  1'b0, 2'b00, 1'b1, 4'd1, 2'd1, 8'd1};
    vecs[6] = '{2'b01, 4'd2, 4'd2, 4'd0,  4'd0,  1'b1, 2'b01, 1'b1, 4'd1, 2'd1, 8'd1};
    vecs[7] = '{2'b00, 4'd0, 4'd0, 4'd0,  4'd0,  1'b1, 2'b00, 1'b1, 4'd4, 2'd0, 8'd2};
    vecs[8] = '{2'b00, 4'd0, 4'd0, 4'd0,  4'd0,  1'b1, 2'b00, 1'b0, 4'd4, 2'd0, 8'd3};

    do_reset();
    for (int i = 0; i < 9; i++) begin
      cyc2(vecs[i].valid, vecs[i].a0, vecs[i].b0, vecs[i].a1, vecs[i].b1, vecs[i].rdy);
      check($sformatf("tbl%0d_ready", i), 32'(req_ready), 32'(vecs[i].e_ready));
      check($sformatf("tbl%0d_valid", i), 32'(res_valid), 32'(vecs[i].e_rvalid));
      if (vecs[i].e_rvalid) begin
        check($sformatf("tbl%0d_p", i),  32'(res_p),  32'(vecs[i].e_p));
        check($sformatf("tbl%0d_id", i), 32'(res_id), 32'(vecs[i].e_id));
      end
      check($sformatf("tbl%0d_ops", i), 32'(ops_done), 32'(vecs[i].e_ops));
    end

    // Contention on two requesters: grants alternate, one result per cycle.
    do_reset();
    for (int k = 0; k <= 6; k++) begin
      cyc2(2'b11, 4'd3, 4'd5, 4'd2, 4'd7, 1'b1);
      check($sformatf("cont%0d_ready", k), 32'(req_ready), (k % 2 == 0) ? 32'd1 : 32'd2);
      check($sformatf("cont%0d_valid", k), 32'(res_valid), (k >= 1) ? 32'd1 : 32'd0);
      if (k >= 1) begin
        check($sformatf("cont%0d_id", k), 32'(res_id), 32'((k - 1) % 2));
        check($sformatf("cont%0d_p", k),  32'(res_p), ((k - 1) % 2 == 1) ? 32'd14 : 32'd15);
      end
      check($sformatf("cont%0d_ops", k), 32'(ops_done), (k >= 1) ? 32'(k - 1) : 32'd0);
    end

    // Hold a result, then assert reset mid-cycle: everything clears without an edge.
    cyc2(2'b11, 4'd0, 4'd0, 4'd0, 4'd0, 1'b0);
    check("hold_ready", 32'(req_ready), 32'd0);
    check("hold_valid", 32'(res_valid), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_valid", 32'(res_valid), 32'd0);
    check("arst_ops",   32'(ops_done),  32'd0);
    check("arst_ready", 32'(req_ready), 32'd0);
    @(posedge clk);
    #2;
    rst_n = 1'b1;

    // Pointer restarts at 0 and the first edge after release accepts.
    // 258 cycles of full throughput give 256 drains, so the counter wraps.
    for (int k = 0; k <= 257; k++) begin
      cyc2(2'b11, 4'd1, 4'd1, 4'd1, 4'd1, 1'b1);
      if (k == 0) check("post_rst_ready", 32'(req_ready), 32'd1);
      if (k == 1) check("post_rst_valid", 32'(res_valid), 32'd1);
      if (k == 256) check("wrap_ops_255", 32'(ops_done), 32'd255);
      if (k == 257) check("wrap_ops_0",   32'(ops_done), 32'd0);
    end

    // Three requesters, only 1 and 2 valid: grants 1,2,1,2.
    cyc2(2'b00, 4'd0, 4'd0, 4'd0, 4'd0, 1'b1);
    for (int k = 0; k <= 4; k++) begin
      @(negedge clk);
      valid3 = 3'b110; rdy3 = 1'b1;
      a3 = {4'd3, 4'd2, 4'd1}; b3 = {4'd3, 4'd2, 4'd1};
      req_valid = '0;
      #1;
      if (k < 4) check($sformatf("n3_%0d_ready", k), 32'(ready3), (k % 2 == 0) ? 32'd2 : 32'd4);
      if (k >= 1) begin
        check($sformatf("n3_%0d_id", k), 32'(id3), (k % 2 == 1) ? 32'd1 : 32'd2);
        check($sformatf("n3_%0d_p", k),  32'(p3),  (k % 2 == 1) ? 32'd4 : 32'd9);
      end
    end
    @(negedge clk);
    valid3 = '0;

    // All 256 operand pairs through requester 1.
    for (int k = 0; k <= 256; k++) begin
      logic [7:0] kk;
      int pa, pb;
      kk = 8'(k);
      cyc2((k < 256) ? 2'b10 : 2'b00, 4'd0, 4'd0, kk[7:4], kk[3:0], 1'b1);
      if (k < 256) check($sformatf("exh%0d_ready", k), 32'(req_ready), 32'd2);
      if (k > 0) begin
        pa = (k - 1) / 16;
        pb = (k - 1) % 16;
        check($sformatf("exh%0d_p", k - 1), 32'(res_p), 32'((pa * pb) % 16));
        check($sformatf("exh%0d_id", k - 1), 32'(res_id), 32'd1);
      end
    end

    // Random traffic against a transaction-level model.
    do_reset();
    begin
      int   m_ptr, m_id, m_p, m_ops;
      bit   m_full;
      m_ptr = 0; m_id = 0; m_p = 0; m_ops = 0; m_full = 0;
      for (int n = 0; n < 400; n++) begin
        logic [1:0] v;
        logic [7:0] ra, rb;
        logic       rdy;
        bit         found, drn;
        int         widx, exp_ready;
        v   = 2'($urandom);
        ra  = 8'($urandom);
        rb  = 8'($urandom);
        rdy = ($urandom_range(0, 9) < 7);
        cyc2(v, ra[3:0], rb[3:0], ra[7:4], rb[7:4], rdy);
        found = 0; widx = 0;
        for (int j = 0; j < 2; j++) begin
          int c;
          c = (m_ptr + j) % 2;
          if (!found && v[c]) begin found = 1; widx = c; end
        end
        exp_ready = (found && (!m_full || rdy)) ? (1 << widx) : 0;
        check("rnd_ready", 32'(req_ready), 32'(exp_ready));
        check("rnd_valid", 32'(res_valid), 32'(m_full));
        if (m_full) begin
          check("rnd_p",  32'(res_p),  32'(m_p));
          check("rnd_id", 32'(res_id), 32'(m_id));
        end
        check("rnd_ops", 32'(ops_done), 32'(m_ops));
        drn = m_full && rdy;
        if (drn) m_ops = (m_ops + 1) % 256;
        if (exp_ready != 0) begin
          m_full = 1;
          m_id   = widx;
          m_p    = (widx == 0) ? (int'(ra[3:0]) * int'(rb[3:0])) % 16
                               : (int'(ra[7:4]) * int'(rb[7:4])) % 16;
          m_ptr  = (widx + 1) % 2;
        end else if (drn) begin
          m_full = 0;
        end
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
